sa_skew_feeder: RTL and testbench
=================================

Name: sa_skew_feeder

Overview:
Parametrised activation feeder that sits between the activation buffer and the systolic core's activation port.
- Accepts one ROWS-wide activation vector per cycle over a valid/ready handshake.
- Applies the diagonal skew the array needs: row r is delayed r extra cycles.
- After a programmed tile length, drains the skew pipeline with zero bubbles and pulses done.
- Honours core backpressure through a global advance enable.

Parameters:
ROWS, 8, number of array rows / skew lanes (>=1)
DW, 8, activation width per row in bits
KMAX, 16, maximum vectors per tile
CW, $clog2(KMAX+1), width of tile-length field

Ports:
clk  in  1  system clock, all state on rising edge
rstn  in  1  asynchronous active-low reset
start  in  1  begin tile; sampled only in IDLE
k_len  in  CW  vectors in tile (0..KMAX), latched on accepted start
in_valid  in  1  in_data holds a vector
in_ready  out  1  feeder accepts in_data this cycle
in_data  in  ROWS*DW  vector; row r = bits [r*DW +: DW]
core_ready  in  1  core can advance; 0 freezes all skew state
a_out  out  ROWS*DW  skewed activations to core, row r = [r*DW +: DW]
a_valid  out  ROWS  per-row valid tag aligned with a_out
busy  out  1  high in FEED or DRAIN
done  out  1  one-cycle pulse at tile completion

Behaviour:
- Reset (async, rstn=0): state=IDLE, all skew stages and tags=0, a_out=0, a_valid=0, in_ready=0, busy=0, done=0, counters=0. Reset mid-tile aborts the tile. No done is issued.
- Skew pipeline: row r is a shift chain of r+1 registers carrying {tag, DW data}. a_out row r is the last stage of that chain. Outputs are fully registered.
- Advance: advance = core_ready && state != IDLE. When advance=0, every stage, counter and the state hold.
- Stage-0 load on advance:
  - FEED, accept (in_valid && in_ready): all rows load {1, in_data row}.
  - FEED, no accept: all rows load {0, 0}. This is a bubble column; skew alignment is preserved.
  - DRAIN: all rows load {0, 0}.
- Latency: a vector accepted at edge E appears on row r at edge E+r, counting advancing edges only.
- in_ready = (state==FEED) && core_ready. It is combinational from state and core_ready. It has no dependence on in_valid.
- FSM:
  - IDLE: on start, latch k_len into klen_q and clear feed_cnt and drain_cnt.
    - k_len=0: stay IDLE and assert done for one cycle on the next edge.
    - k_len>0: go to FEED.
  - FEED: feed_cnt increments per accept. On the accept that makes feed_cnt==klen_q:
    - ROWS>1: go to DRAIN.
    - ROWS==1: go to IDLE with done=1 that edge.
  - DRAIN: drain_cnt increments per advancing edge. On the advance that makes drain_cnt==ROWS-1, go to IDLE with done=1 on that edge. On that same edge the last vector's row ROWS-1 element becomes visible on a_out.
  - IDLE after DRAIN: pipeline contents are all bubbles, so a_valid=0.
- start is ignored while busy. k_len>KMAX is clamped to KMAX.
- busy = (state != IDLE). It is registered with the state.
- done is a registered single-cycle pulse and is never asserted while rstn=0.
- Simultaneous start and done (returning to IDLE): the start is not seen that cycle because the FSM is not yet in IDLE. It is accepted the cycle after.

Test Plan:
- Reset/idle: ROWS=4, DW=8, KMAX=16; hold rstn=0 4 cycles, then release -> a_out=0, a_valid=0, in_ready=0, busy=0, done=0.
- Basic skew, k_len=3, core_ready=1, in_valid=1, vectors {r=0..3: 0x10+r}, {0x20+r}, {0x30+r} -> row r emits 0x10+r, 0x20+r, 0x30+r starting r edges after row 0. Row 3 sees 0x33 on the edge done=1. busy covers exactly 3+3 advancing cycles.
- Input bubbles: k_len=2, in_valid low 2 cycles between vectors -> every row shows a 2-cycle a_valid=0 gap at the same relative offset. Total busy = 2+2+3 cycles.
- Backpressure: k_len=4, core_ready=0 for 3 cycles mid-FEED and 2 cycles mid-DRAIN -> in_ready=0 and a_out/a_valid frozen during stalls. done is delayed by exactly 5 cycles versus the no-stall run. Data is unchanged.
- Edge lengths: k_len=0 -> done 1 cycle after start, busy never high. k_len=16 -> 16 accepts, then 3 drain cycles. k_len=20 -> clamped, exactly 16 accepts.
- Async reset mid-DRAIN: assert rstn=0 between edges -> outputs clear immediately, no done pulse. A subsequent start with k_len=1 completes normally.

Source files
------------

// File: rtl/sa_skew_feeder.sv
// Activation feeder for the systolic core: accepts ROWS-wide vectors and skews
// row r by r cycles, drains the skew after a programmed tile length, then pulses done.
module sa_skew_feeder #(
    parameter int ROWS = 8,
    parameter int DW   = 8,
    parameter int KMAX = 16,
    parameter int CW   = $clog2(KMAX + 1)
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               start_i,
    input  logic [CW-1:0]      k_len_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [ROWS*DW-1:0] in_data_i,
    input  logic               core_ready_i,
    output logic [ROWS*DW-1:0] a_out_o,
    output logic [ROWS-1:0]    a_valid_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int DCW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0]  KMAX_C     = CW'(KMAX);
    localparam logic [DCW-1:0] DRAIN_LAST = DCW'(ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [CW-1:0]  klen_q, klen_d;
    logic [CW-1:0]  feed_cnt_q, feed_cnt_d;
    logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
    logic           done_q, done_d;

    logic           advance;
    logic           accept;
    logic           flush;
    logic [CW-1:0]  k_clamped;
    logic [CW-1:0]  feed_nxt;
    logic [DCW-1:0] drain_nxt;

    assign advance    = core_ready_i && (state_q != IDLE);
    assign in_ready_o = (state_q == FEED) && core_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign k_clamped  = (k_len_i > KMAX_C) ? KMAX_C : k_len_i;
    assign feed_nxt   = feed_cnt_q + CW'(1);
    assign drain_nxt  = drain_cnt_q + DCW'(1);
    // The completion edge leaves the last element visible for one cycle; the
    // following idle edge clears it so a stalled-idle core never re-consumes it.
    assign flush      = (state_q == IDLE) && done_q;

    always_comb begin
        state_d     = state_q;
        klen_d      = klen_q;
        feed_cnt_d  = feed_cnt_q;
        drain_cnt_d = drain_cnt_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    klen_d      = k_clamped;
                    feed_cnt_d  = '0;
                    drain_cnt_d = '0;
                    if (k_clamped == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = FEED;
                    end
                end
            end
            FEED: begin
                if (accept) begin
                    feed_cnt_d = feed_nxt;
                    if (feed_nxt == klen_q) begin
                        if (ROWS > 1) begin
                            state_d = DRAIN;
                        end else begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            DRAIN: begin
                if (advance) begin
                    drain_cnt_d = drain_nxt;
                    if (drain_nxt == DRAIN_LAST) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            klen_q      <= '0;
            feed_cnt_q  <= '0;
            drain_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            klen_q      <= klen_d;
            feed_cnt_q  <= feed_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            done_q      <= done_d;
        end
    end

    // Row gi is a chain of gi+1 {tag, data} stages; bubbles keep the diagonal aligned.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        logic [DW:0] stage_q [0:gi];
        logic [DW:0] load_d;

        assign load_d = accept ? {1'b1, in_data_i[gi*DW +: DW]} : '0;

        always_ff @(posedge clk_i or negedge rstn_i) begin
            if (!rstn_i) begin
                for (int j = 0; j <= gi; j++) begin
                    stage_q[j] <= '0;
                end
            end else if (advance) begin
                stage_q[0] <= load_d;
                for (int j = 1; j <= gi; j++) begin
                    stage_q[j] <= stage_q[j-1];
                end
            end else if (flush) begin
                for (int j = 0; j <= gi; j++) begin
                    stage_q[j] <= '0;
                end
            end
        end

        assign a_out_o[gi*DW +: DW] = stage_q[gi][DW-1:0];
        assign a_valid_o[gi]        = stage_q[gi][DW];
    end

    assign busy_o = (state_q != IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_sa_skew_feeder.sv
// Directed bench for sa_skew_feeder: the driver pushes expected per-row elements
// (value and advancing-edge index) on each accept, a monitor pops on every a_valid.
module tb_sa_skew_feeder;

    localparam int ROWS = 4;
    localparam int DW   = 8;
    localparam int KMAX = 16;
    localparam int CW   = $clog2(KMAX + 1);

    logic               clk = 1'b0;
    logic               rstn = 1'b1;
    logic               start = 1'b0;
    logic [CW-1:0]      k_len = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [ROWS*DW-1:0] in_data = '0;
    logic               core_ready = 1'b1;
    logic [ROWS*DW-1:0] a_out;
    logic [ROWS-1:0]    a_valid;
    logic               busy;
    logic               done;

    sa_skew_feeder #(.ROWS(ROWS), .DW(DW), .KMAX(KMAX), .CW(CW)) dut (
        .clk_i       (clk),
        .rstn_i      (rstn),
        .start_i     (start),
        .k_len_i     (k_len),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .core_ready_i(core_ready),
        .a_out_o     (a_out),
        .a_valid_o   (a_valid),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        int            t;
    } item_t;

    item_t exp_q [ROWS][$];
    int    n_vec   = 0;
    int    n_err   = 0;
    int    adv_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [DW-1:0] vbyte(input int salt, input int v, input int r);
        return DW'(salt + 16 * (v + 1) + r);
    endfunction

    // Monitor: checks stall freezing and every emitted element against the scoreboard.
    initial begin
        logic               cr_p, busy_p, rst_p;
        logic [ROWS*DW-1:0] ao_p;
        logic [ROWS-1:0]    av_p;
        item_t              it;
        forever begin
            @(negedge clk);
            #2;
            cr_p   = core_ready;
            busy_p = busy;
            ao_p   = a_out;
            av_p   = a_valid;
            rst_p  = rstn;
            @(posedge clk);
            #1;
            if (!rst_p || !rstn) continue;
            if (!cr_p && busy_p) begin
                check("stall a_out", a_out, ao_p);
                check("stall a_valid", a_valid, av_p);
            end
            if (cr_p && busy_p) begin
                adv_cnt++;
                for (int r = 0; r < ROWS; r++) begin
                    if (a_valid[r]) begin
                        if (exp_q[r].size() == 0) begin
                            check($sformatf("row%0d spurious valid", r), a_valid[r], 1'b0);
                        end else begin
                            it = exp_q[r].pop_front();
                            check($sformatf("row%0d data", r), a_out[r*DW +: DW], it.d);
                            check($sformatf("row%0d edge", r), adv_cnt, it.t);
                        end
                    end else if (exp_q[r].size() > 0 && exp_q[r][0].t <= adv_cnt) begin
                        check($sformatf("row%0d missing valid", r), a_valid[r], 1'b1);
                    end
                end
            end
        end
    end

    // One tile: stall windows are [s,s+l) in edges counted from the start edge (=0).
    task automatic run_tile(input string name, input int klen, input int nvec, input int salt,
                            input int gap, input int s1, input int l1, input int s2, input int l2,
                            input int abort_at, input int exp_acc, input int exp_lat,
                            input int exp_busy);
        int  c = 0, v = 0, gapcnt = 0, acc = 0, busyc = 0, lat = -1, kc;
        bit  fin = 0;
        bit  exp_ir;
        kc = (klen > KMAX) ? KMAX : klen;
        @(negedge clk);
        start      = 1'b1;
        k_len      = CW'(klen);
        in_valid   = 1'b0;
        core_ready = 1'b1;
        for (int i = 0; i < 400 && !fin; i++) begin
            @(posedge clk);
            #1;
            c++;
            if (done) begin
                fin = 1;
                lat = c;
            end
            if (busy) busyc++;
            if (!fin) begin
                @(negedge clk);
                start = 1'b0;
                if (c == abort_at) begin
                    core_ready = 1'b1;
                    in_valid   = 1'b0;
                    rstn       = 1'b0;
                    #1;
                    check({name, " a_valid"}, a_valid, '0);
                    check({name, " a_out"}, a_out, '0);
                    check({name, " busy"}, busy, 1'b0);
                    check({name, " done"}, done, 1'b0);
                    check({name, " in_ready"}, in_ready, 1'b0);
                    for (int r = 0; r < ROWS; r++) exp_q[r].delete();
                    repeat (2) begin
                        @(posedge clk);
                        #1;
                        check({name, " done in reset"}, done, 1'b0);
                    end
                    @(negedge clk);
                    rstn = 1'b1;
                    $display("tile %s: aborted by reset at edge %0d", name, c);
                    return;
                end
                core_ready = !((c >= s1 && c < s1 + l1) || (c >= s2 && c < s2 + l2));
                if (gapcnt > 0) begin
                    in_valid = 1'b0;
                    gapcnt--;
                end else if (v < nvec) begin
                    in_valid = 1'b1;
                    for (int r = 0; r < ROWS; r++) in_data[r*DW +: DW] = vbyte(salt, v, r);
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                exp_ir = core_ready && (kc > 0) && (acc < kc);
                check({name, " in_ready"}, in_ready, exp_ir);
                if (in_valid && in_ready) begin
                    for (int r = 0; r < ROWS; r++)
                        exp_q[r].push_back('{d: vbyte(salt, v, r), t: adv_cnt + 1 + r});
                    v++;
                    acc++;
                    gapcnt = gap;
                end
            end
        end
        @(negedge clk);
        start      = 1'b0;
        in_valid   = 1'b0;
        core_ready = 1'b1;
        check({name, " accepts"}, acc, exp_acc);
        check({name, " done latency"}, lat, exp_lat);
        check({name, " busy cycles"}, busyc, exp_busy);
        for (int r = 0; r < ROWS; r++)
            check($sformatf("%s row%0d drained", name, r), exp_q[r].size(), 0);
        @(posedge clk);
        #1;
        check({name, " idle a_valid"}, a_valid, '0);
        check({name, " idle a_out"}, a_out, '0);
        $display("tile %s: k_len=%0d accepts=%0d done_after=%0d busy=%0d", name, klen, acc, lat, busyc);
    endtask

    initial begin
        #2 rstn = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        check("reset a_out", a_out, '0);
        check("reset a_valid", a_valid, '0);
        check("reset in_ready", in_ready, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        rstn = 1'b1;
        $display("reset: outputs idle");

        //        name        k   n  salt  gap s1 l1 s2  l2 abort acc lat busy
        run_tile("basic",     3,  3, 0,    0,  0, 0, 0,  0, -1,   3,  7,  6);
        run_tile("bubbles",   2,  2, 8'h80, 2, 0, 0, 0,  0, -1,   2,  8,  7);
        run_tile("k4_nostall",4,  4, 8'h40, 0, 0, 0, 0,  0, -1,   4,  8,  7);
        run_tile("k4_stall",  4,  4, 8'h40, 0, 3, 3, 10, 2, -1,   4,  13, 12);
        run_tile("k0",        0,  0, 0,    0,  0, 0, 0,  0, -1,   0,  1,  0);
        run_tile("k16",       16, 16, 8'h03, 0, 0, 0, 0, 0, -1,   16, 20, 19);
        run_tile("k20_clamp", 20, 20, 8'h05, 0, 0, 0, 0, 0, -1,   16, 20, 19);
        run_tile("abort",     2,  2, 8'hA0, 0, 0, 0, 0,  0, 4,    0,  0,  0);
        run_tile("after_rst", 1,  1, 8'hC0, 0, 0, 0, 0,  0, -1,   1,  5,  4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
